// File: rtl/adjust_color_pkg.sv
// Shared types and constants for the HSV colour-adjust pipeline and its stream adapters.
package adjust_color_pkg;

   localparam int ADJ_LATENCY = 26;
   localparam int PIX_W       = 24;

   typedef struct packed {
      logic sof;
      logic eol;
   } sband_t;

   typedef struct packed {
      sband_t           sb;
      logic [PIX_W-1:0] pixel;
   } fifo_word_t;

endpackage

// File: rtl/adjust_color_stream_out_fifo.sv
// First-word-fall-through synchronous FIFO; a push into a full FIFO is accepted only when a pop
// frees the slot in the same cycle.
module sync_fifo_fwft #(
   parameter int WIDTH = 26,
   parameter int DEPTH = 64
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [WIDTH-1:0]       wdata,
   input  logic                   pop,
   output logic [WIDTH-1:0]       rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

endmodule

// File: rtl/adjust_color_stream_out.sv
// Output adapter for the colour-adjust pipeline: credit flow control, sof/eol delay line, FWFT buffer.
// Optional ADJUST_COLOR_STATS_EN adds sticky ovf_err/align_err and a per-frame pixel counter.
module adjust_color_stream_out
   import adjust_color_pkg::*;
#(
   parameter int DATA_W     = PIX_W,
   parameter int LATENCY    = ADJ_LATENCY,
   parameter int FIFO_DEPTH = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              src_valid,
   input  logic              src_sof,
   input  logic              src_eol,
   output logic              src_ready,
   input  logic [DATA_W-1:0] res_data,
   input  logic              res_valid,
   output logic [DATA_W-1:0] m_data,
   output logic              m_user,
   output logic              m_last,
   output logic              m_valid,
   input  logic              m_ready
`ifdef ADJUST_COLOR_STATS_EN
   ,
   output logic              ovf_err,
   output logic              align_err,
   output logic [31:0]       frame_pix_cnt
`endif
);

   localparam int FW     = $clog2(LATENCY + 1);
   localparam int CW     = $clog2(FIFO_DEPTH + 1);
   localparam int WORD_W = $bits(sband_t) + DATA_W;

   typedef struct packed {
      logic   valid;
      sband_t sb;
   } dly_t;

   logic [FW-1:0]             flush_cnt;
   logic                      flushing;
   logic [CW-1:0]             credits;
   logic                      accept;
   logic                      pop;
   logic                      push;
   logic                      credit_inc;
   dly_t                      sband_dly [LATENCY];
   dly_t                      tail;
   logic [WORD_W-1:0]         rdata;
   logic                      full;
   logic                      empty;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;

   assign flushing   = (flush_cnt != '0);
   assign src_ready  = (credits != '0) && !flushing;
   assign accept     = src_valid && src_ready;
   assign pop        = m_valid && m_ready;
   assign credit_inc = pop && (credits != CW'(FIFO_DEPTH));
   assign tail       = sband_dly[LATENCY-1];
   assign push       = res_valid && !flushing;

   // Flush window: results emerging right after reset belong to pixels issued before it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)         flush_cnt <= FW'(LATENCY);
      else if (flushing) flush_cnt <= flush_cnt - FW'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                          credits <= CW'(FIFO_DEPTH);
      else if (accept && !credit_inc)     credits <= credits - CW'(1);
      else if (credit_inc && !accept)     credits <= credits + CW'(1);
   end

   // Sideband stage 0..LATENCY-1: mirrors the pipeline depth so the tail meets res_valid.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < LATENCY; i++) sband_dly[i] <= '0;
      end else begin
         sband_dly[0] <= '{valid: src_valid,
                           sb: '{sof: src_sof & src_valid, eol: src_eol & src_valid}};
         for (int i = 1; i < LATENCY; i++) sband_dly[i] <= sband_dly[i-1];
      end
   end

   // Output buffer stage: word = {sof, eol, pixel}.
   sync_fifo_fwft #(
      .WIDTH (WORD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (reset),
      .push  (push),
      .wdata ({tail.sb, res_data}),
      .pop   (pop),
      .rdata (rdata),
      .full  (full),
      .empty (empty),
      .count (fifo_count)
   );

   assign m_valid = !empty;
   assign {m_user, m_last, m_data} = empty ? '0 : rdata;

`ifdef ADJUST_COLOR_STATS_EN
   logic [31:0] pix_run;
   logic        unused_sig;

   assign unused_sig = ^fifo_count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ovf_err       <= 1'b0;
         align_err     <= 1'b0;
         frame_pix_cnt <= '0;
         pix_run       <= '0;
      end else begin
         if (push && full && !pop)                 ovf_err   <= 1'b1;
         if (!flushing && (tail.valid != res_valid)) align_err <= 1'b1;
         if (pop) begin
            if (m_user) begin
               frame_pix_cnt <= pix_run;
               pix_run       <= 32'd1;
            end else begin
               pix_run       <= pix_run + 32'd1;
            end
         end
      end
   end
`else
   logic unused_sig;
   assign unused_sig = ^{full, fifo_count, tail.valid};
`endif

endmodule

// File: tb/tb_adjust_color_stream_out.sv
// Randomised bench for adjust_color_stream_out; a delay-line stand-in models the colour pipeline.
module tb_adjust_color_stream_out;
   import adjust_color_pkg::*;

   localparam int LAT   = ADJ_LATENCY;
   localparam int DEPTH = 64;

   typedef logic [PIX_W+1:0] word_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             reset, src_valid, src_sof, src_eol, src_ready;
   logic             res_valid, m_user, m_last, m_valid, m_ready;
   logic [PIX_W-1:0] res_data, m_data, src_data, force_data;
   logic             force_res, pipe_clr;
`ifdef ADJUST_COLOR_STATS_EN
   logic             ovf_err, align_err;
   logic [31:0]      frame_pix_cnt;
`endif
   logic [PIX_W:0]   pipe [LAT];

   adjust_color_stream_out dut (
      .clk       (clk),
      .reset     (reset),
      .src_valid (src_valid),
      .src_sof   (src_sof),
      .src_eol   (src_eol),
      .src_ready (src_ready),
      .res_data  (res_data),
      .res_valid (res_valid),
      .m_data    (m_data),
      .m_user    (m_user),
      .m_last    (m_last),
      .m_valid   (m_valid),
      .m_ready   (m_ready)
`ifdef ADJUST_COLOR_STATS_EN
      ,
      .ovf_err       (ovf_err),
      .align_err     (align_err),
      .frame_pix_cnt (frame_pix_cnt)
`endif
   );

   // Stand-in for the colour pipeline: fixed delay, not reset, so in-flight pixels survive a reset.
   always @(posedge clk) begin
      if (pipe_clr) begin
         for (int i = 0; i < LAT; i++) pipe[i] <= '0;
      end else begin
         pipe[0] <= {src_valid, src_data};
         for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
      end
   end
   assign res_valid = pipe[LAT-1][PIX_W] | force_res;
   assign res_data  = force_res ? force_data : pipe[LAT-1][PIX_W-1:0];

   word_t exp_q[$];
   word_t got_q[$];
   int    vectors, errors;
   int    outstanding, flush_left;
   logic  s_rdy, s_mv, exp_rdy;
   word_t s_word;

   // One clock: sample mid-cycle, update the reference model, advance past the edge.
   task automatic step();
      @(negedge clk);
      s_rdy   = src_ready;
      s_mv    = m_valid;
      s_word  = {m_user, m_last, m_data};
      exp_rdy = (flush_left == 0) && (outstanding < DEPTH);
      if (src_valid && src_ready) begin
         exp_q.push_back({src_sof, src_eol, src_data});
         outstanding++;
      end
      if (m_valid && m_ready) begin
         got_q.push_back(s_word);
         if (outstanding > 0) outstanding--;
      end
      if (flush_left > 0) flush_left--;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(int cyc);
      reset = 1'b1; src_valid = 1'b0; m_ready = 1'b0; force_res = 1'b0;
      repeat (cyc) @(posedge clk);
      #1 reset = 1'b0;
      exp_q.delete(); got_q.delete();
      outstanding = 0; flush_left = LAT;
   endtask

   task automatic fill(int n);
      m_ready = 1'b0;
      for (int i = 0; i < n; i++) begin
         src_valid = 1'b1; src_sof = (i == 0); src_eol = (i == n - 1);
         src_data  = PIX_W'($urandom);
         step();
      end
      src_valid = 1'b0; src_sof = 1'b0; src_eol = 1'b0;
   endtask

   task automatic drain();
      m_ready = 1'b1;
      for (int n = 0; n < 3000 && got_q.size() < exp_q.size(); n++) step();
      m_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if ({m_valid, m_user, m_last, src_ready} !== 4'b0 || m_data !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got valid=%b user=%b last=%b rdy=%b data=%h, expected all 0",
                  m_valid, m_user, m_last, src_ready, m_data);
      end
`ifdef ADJUST_COLOR_STATS_EN
      vectors++;
      if ({ovf_err, align_err} !== 2'b00 || frame_pix_cnt !== 32'd0) begin
         errors++;
         $display("FAIL reset_stats: got ovf=%b align=%b cnt=%0d, expected 0", ovf_err, align_err, frame_pix_cnt);
      end
`endif
      #1 reset = 1'b0;
      exp_q.delete(); got_q.delete(); outstanding = 0; flush_left = LAT;
      for (int k = 1; k <= LAT + 1; k++) begin
         step();
         vectors++;
         if (s_rdy !== exp_rdy) begin
            errors++;
            $display("FAIL flush_ready: cycle %0d got %b expected %b", k, s_rdy, exp_rdy);
         end
      end
   endtask

   task automatic test_single_pixel();
      int k;
      src_valid = 1'b1; src_sof = 1'b1; src_eol = 1'b1; src_data = 24'h123456;
      step();
      src_valid = 1'b0; src_sof = 1'b0; src_eol = 1'b0;
      for (k = 1; k <= 40; k++) begin
         step();
         if (s_mv) break;
      end
      vectors++;
      if (k != LAT + 1) begin
         errors++;
         $display("FAIL single_latency: got %0d cycles expected %0d", k, LAT + 1);
      end
      vectors++;
      if (s_word !== {2'b11, 24'h123456}) begin
         errors++;
         $display("FAIL single_word: got %h expected %h", s_word, {2'b11, 24'h123456});
      end
      drain();
      vectors++;
      if (got_q.size() != 1 || exp_q.size() != 1) begin
         errors++;
         $display("FAIL single_count: got %0d words expected 1", got_q.size());
      end
      exp_q.delete(); got_q.delete();
   endtask

   task automatic test_backpressure();
      fill(DEPTH);
      vectors++;
      if (exp_q.size() != DEPTH || src_ready !== 1'b0) begin
         errors++;
         $display("FAIL credit_exhaust: got %0d accepts rdy=%b expected %0d rdy=0", exp_q.size(), src_ready, DEPTH);
      end
      repeat (LAT + 2) step();
      vectors++;
      if (s_mv !== 1'b1 || s_rdy !== 1'b0) begin
         errors++;
         $display("FAIL full_hold: got valid=%b rdy=%b expected valid=1 rdy=0", s_mv, s_rdy);
      end
`ifdef ADJUST_COLOR_STATS_EN
      vectors++;
      if (ovf_err !== 1'b0) begin
         errors++;
         $display("FAIL no_ovf: got %b expected 0", ovf_err);
      end
`endif
      drain();
      vectors++;
      if (got_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL fill_count: got %0d words expected %0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         vectors++;
         if (got_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL fill_word[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
         end
      end
      vectors++;
      if (m_valid !== 1'b0 || src_ready !== 1'b1) begin
         errors++;
         $display("FAIL fill_end: got valid=%b rdy=%b expected valid=0 rdy=1", m_valid, src_ready);
      end
      exp_q.delete(); got_q.delete();
   endtask

   task automatic test_frame();
      int    sent = 0;
      logic  mr;
      logic  pmv = 1'b0;
      logic  pmr = 1'b1;
      word_t pw = '0;
      for (int n = 0; n < 3000 && got_q.size() < 9; n++) begin
         m_ready   = ($urandom_range(0, 9) < 3);
         src_valid = (sent < 9) && src_ready && ($urandom_range(0, 1) == 1);
         src_data  = PIX_W'($urandom);
         src_sof   = (sent % 8 == 0);
         src_eol   = (sent % 4 == 3);
         mr = m_ready;
         step();
         if (pmv && !pmr) begin
            vectors++;
            if (!s_mv || s_word !== pw) begin
               errors++;
               $display("FAIL hold_stable: got valid=%b word=%h expected valid=1 word=%h", s_mv, s_word, pw);
            end
         end
         pmv = s_mv; pmr = mr; pw = s_word;
         if (exp_q.size() > sent) sent++;
      end
      m_ready = 1'b0; src_valid = 1'b0; src_sof = 1'b0; src_eol = 1'b0;
      vectors++;
      if (got_q.size() != 9) begin
         errors++;
         $display("FAIL frame_count: got %0d words expected 9", got_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         vectors++;
         if (got_q[i] !== exp_q[i] || got_q[i][PIX_W+1] !== (i % 8 == 0) || got_q[i][PIX_W] !== (i % 4 == 3)) begin
            errors++;
            $display("FAIL frame_word[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
         end
      end
`ifdef ADJUST_COLOR_STATS_EN
      vectors++;
      if (frame_pix_cnt !== 32'd8) begin
         errors++;
         $display("FAIL frame_pix_cnt: got %0d expected 8", frame_pix_cnt);
      end
`endif
      drain();
      exp_q.delete(); got_q.delete();
   endtask

   task automatic test_reset_inflight();
      fill(10);
      do_reset(2);
      for (int k = 1; k <= 40; k++) begin
         step();
         vectors++;
         if (s_rdy !== exp_rdy) begin
            errors++;
            $display("FAIL reflush_ready: cycle %0d got %b expected %b", k, s_rdy, exp_rdy);
         end
         vectors++;
         if (s_mv !== 1'b0) begin
            errors++;
            $display("FAIL stale_word: cycle %0d got valid=%b word=%h expected valid=0", k, s_mv, s_word);
         end
      end
      src_valid = 1'b1; src_sof = 1'b1; src_eol = 1'b0; src_data = 24'h00beef;
      step();
      src_valid = 1'b0; src_sof = 1'b0;
      drain();
      vectors++;
      if (got_q.size() != 1 || got_q[0] !== {2'b10, 24'h00beef}) begin
         errors++;
         $display("FAIL post_reset_word: got %0d words first %h expected 1 word %h",
                  got_q.size(), (got_q.size() > 0) ? got_q[0] : word_t'(0), {2'b10, 24'h00beef});
      end
      exp_q.delete(); got_q.delete();
   endtask

   task automatic test_overflow();
      fill(DEPTH);
      repeat (LAT + 2) step();
      force_res = 1'b1; force_data = 24'haaaaaa;
      step();
      force_res = 1'b0;
`ifdef ADJUST_COLOR_STATS_EN
      vectors++;
      if (ovf_err !== 1'b1 || align_err !== 1'b1) begin
         errors++;
         $display("FAIL ovf_flags: got ovf=%b align=%b expected 1 1", ovf_err, align_err);
      end
`endif
      force_res = 1'b1; force_data = 24'hbbbbbb; m_ready = 1'b1;
      step();
      force_res = 1'b0; m_ready = 1'b0;
      exp_q.push_back({2'b00, 24'hbbbbbb});
      drain();
      repeat (3) step();
      vectors++;
      if (got_q.size() != DEPTH + 1 || s_mv !== 1'b0) begin
         errors++;
         $display("FAIL ovf_count: got %0d words valid=%b expected %0d valid=0", got_q.size(), s_mv, DEPTH + 1);
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         vectors++;
         if (got_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL ovf_word[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
         end
      end
      exp_q.delete(); got_q.delete();
   endtask

   task automatic test_credit_zero();
      fill(DEPTH);
      repeat (LAT + 2) step();
      m_ready = 1'b1;
      step();
      m_ready = 1'b0;
      vectors++;
      if (s_rdy !== 1'b0 || got_q.size() != 1 || src_ready !== 1'b1) begin
         errors++;
         $display("FAIL zero_pop: got rdy=%b pops=%0d next_rdy=%b expected 0 1 1", s_rdy, got_q.size(), src_ready);
      end
      src_valid = 1'b1; src_data = PIX_W'($urandom); m_ready = 1'b1;
      step();
      src_valid = 1'b0; m_ready = 1'b0;
      vectors++;
      if (src_ready !== 1'b1 || got_q.size() != 2) begin
         errors++;
         $display("FAIL accept_and_pop: got rdy=%b pops=%0d expected rdy=1 pops=2", src_ready, got_q.size());
      end
      src_valid = 1'b1; src_data = PIX_W'($urandom);
      step();
      src_valid = 1'b0;
      vectors++;
      if (src_ready !== 1'b0) begin
         errors++;
         $display("FAIL last_credit: got rdy=%b expected 0", src_ready);
      end
      drain();
      vectors++;
      if (got_q.size() != DEPTH + 2) begin
         errors++;
         $display("FAIL zero_count: got %0d words expected %0d", got_q.size(), DEPTH + 2);
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         vectors++;
         if (got_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL zero_word[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
         end
      end
      exp_q.delete(); got_q.delete();
   endtask

   initial begin
      reset = 1'b1; src_valid = 1'b0; src_sof = 1'b0; src_eol = 1'b0; src_data = '0;
      m_ready = 1'b0; force_res = 1'b0; force_data = '0; pipe_clr = 1'b1;
      vectors = 0; errors = 0; outstanding = 0; flush_left = LAT;
      @(posedge clk);
      #1 pipe_clr = 1'b0;
      test_reset();
      test_single_pixel();
      test_backpressure();
      test_frame();
      test_reset_inflight();
      test_overflow();
      test_credit_zero();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
